wb_arbiter: RTL

Parametrised write-back arbiter between the execution units (alu, jump_branch, data_memory_ctrl, future units) and the single register_file write port. It replaces the combinational priority mux in the core top. Each source gets a valid/ready handshake and its own small FIFO, so two units can complete in the same cycle without losing a write. A fixed-priority or round-robin arbiter drains the FIFOs into a registered write port.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_src_fifo.sv | 66 ++++++
 rtl/wb_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and entry type for the write-back arbiter.
// Entries are packed {addr, data} with data in the low bits.
package wb_pkg;

  localparam int ARB_FIXED      = 0;
  localparam int ARB_RR         = 1;
  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;

  typedef struct packed {
    logic [REG_ADDR_W_DEF-1:0] addr;
    logic [XLEN_DEF-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_src_fifo.sv
// wb_src_fifo: per-source circular FIFO for write-back entries.
// With WB_HAZARD_EN it also exposes per-slot valid bits and address keys.
module wb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
`ifdef WB_HAZARD_EN
  ,
  parameter int KEY_W = 5
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic                   full,
  output logic                   empty,
  output logic [W-1:0]           head
`ifdef WB_HAZARD_EN
  ,
  output logic [DEPTH-1:0]       ent_vld,
  output logic [DEPTH*KEY_W-1:0] ent_key
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

`ifdef WB_HAZARD_EN
  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i] = ({1'b0, PW'(i) - rd_ptr} < count);
      ent_key[i*KEY_W +: KEY_W] = mem[i][W-1 -: KEY_W];
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: per-source FIFOs drained by a fixed/round-robin arbiter
// into a registered register-file write port. Option: WB_HAZARD_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int FIFO_DEPTH = 2,
  parameter int ARB_MODE   = ARB_FIXED
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*XLEN-1:0]       src_data,
  output logic                          wr_en,
  output logic [REG_ADDR_W-1:0]         wr_index,
  output logic [XLEN-1:0]               wr_data,
  output logic                          busy
`ifdef WB_HAZARD_EN
  ,
  input  logic [REG_ADDR_W-1:0]         rd_index1,
  input  logic [REG_ADDR_W-1:0]         rd_index2,
  output logic                          hazard1,
  output logic                          hazard2
`endif
);

  localparam int EW = REG_ADDR_W + XLEN;
  localparam int SW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [EW-1:0]      head [NUM_SRC];

`ifdef WB_HAZARD_EN
  logic [FIFO_DEPTH-1:0]            ent_vld [NUM_SRC];
  logic [FIFO_DEPTH*REG_ADDR_W-1:0] ent_key [NUM_SRC];
`endif

  logic                  gnt_vld;
  logic [SW-1:0]         gnt_idx;
  logic [SW-1:0]         rr_ptr;
  logic [EW-1:0]         gnt_head;
  logic [REG_ADDR_W-1:0] gnt_addr;

  assign src_ready = ~full;
  assign push      = src_valid & ~full;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    wb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EW)
`ifdef WB_HAZARD_EN
      ,
      .KEY_W (REG_ADDR_W)
`endif
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push[i]),
      .pop     (pop[i]),
      .din     ({src_addr[i*REG_ADDR_W +: REG_ADDR_W],
                 src_data[i*XLEN +: XLEN]}),
      .full    (full[i]),
      .empty   (empty[i]),
      .head    (head[i])
`ifdef WB_HAZARD_EN
      ,
      .ent_vld (ent_vld[i]),
      .ent_key (ent_key[i])
`endif
    );
  end

  // Round robin starts one past the last winner; fixed mode starts at 0.
  always_comb begin
    int base;
    int j;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    base    = (ARB_MODE == ARB_RR) ? int'(rr_ptr) + 1 : 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = (base + k) % NUM_SRC;
      if (!gnt_vld && !empty[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'(j);
      end
    end
  end

  assign gnt_head = head[gnt_idx];
  assign gnt_addr = gnt_head[EW-1 -: REG_ADDR_W];
  assign pop      = gnt_vld ? (NUM_SRC'(1) << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_index <= '0;
      wr_data  <= '0;
      rr_ptr   <= SW'(NUM_SRC-1);
    end else begin
      wr_en <= gnt_vld && (gnt_addr != '0);
      if (gnt_vld) begin
        wr_index <= gnt_addr;
        wr_data  <= gnt_head[XLEN-1:0];
        rr_ptr   <= gnt_idx;
      end
    end
  end

  assign busy = ~(&empty) | wr_en;

`ifdef WB_HAZARD_EN
  always_comb begin
    hazard1 = wr_en && (wr_index == rd_index1);
    hazard2 = wr_en && (wr_index == rd_index2);
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        if (ent_vld[s][e]) begin
          if (ent_key[s][e*REG_ADDR_W +: REG_ADDR_W] == rd_index1)
            hazard1 = 1'b1;
          if (ent_key[s][e*REG_ADDR_W +: REG_ADDR_W] == rd_index2)
            hazard2 = 1'b1;
        end
      end
    end
    if (rd_index1 == '0) hazard1 = 1'b0;
    if (rd_index2 == '0) hazard2 = 1'b0;
  end
`endif

endmodule
